// File: rtl/layer_stream_ctrl.sv
// Layer stream controller: streams one input frame from the frame buffer through
// a conv layer and captures the layer's output beats into the output frame buffer.
module layer_stream_ctrl #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned CH         = 32,
  parameter  int unsigned WIDTH      = 14,
  parameter  int unsigned DOUT       = 196,
  parameter  int unsigned TIMEOUT    = 300,
  localparam int unsigned BW         = DATA_WIDTH * CH,
  localparam int unsigned DIM        = WIDTH * WIDTH,
  localparam int unsigned RAW        = $clog2(DIM),
  localparam int unsigned WAW        = $clog2(DOUT),
  localparam int unsigned CW         = $clog2(DOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           rd_en,
  output logic [RAW-1:0] rd_addr,
  input  logic [BW-1:0]  rd_data,
  output logic [BW-1:0]  lyr_data,
  output logic           lyr_valid_in,
  input  logic [BW-1:0]  lyr_out,
  input  logic           lyr_valid_out,
  output logic           wr_en,
  output logic [WAW-1:0] wr_addr,
  output logic [BW-1:0]  wr_data,
  output logic [CW-1:0]  out_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          capture;
  logic          beat_ok;
  logic          beat_ovf;
  logic          tmo_hit;
  logic          tmo_err;
  logic          accept;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the capture-path decode shared with the datapath.
  always_comb begin
    state_nxt = state;
    capture   = (state == S_FEED) || (state == S_DRAIN);
    beat_ok   = capture && lyr_valid_out && (out_count < CW'(DOUT));
    beat_ovf  = capture && lyr_valid_out && (out_count >= CW'(DOUT));
    cnt_nxt   = beat_ok ? out_count + CW'(1) : out_count;
    tmo_hit   = !lyr_valid_out && (tmo_cnt == TW'(TIMEOUT - 1));
    tmo_err   = (state == S_DRAIN) && tmo_hit && (cnt_nxt != CW'(DOUT));
    accept    = (state == S_IDLE) && start;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FEED;
      S_FEED:  if (rd_addr == RAW'(DIM - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if ((cnt_nxt == CW'(DOUT)) || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The layer sees the buffer data directly; the write port follows the layer output.
  always_comb begin
    lyr_data = rd_data;
    wr_en    = beat_ok;
    wr_addr  = WAW'(out_count);
    wr_data  = lyr_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      lyr_valid_in <= 1'b0;
      out_count    <= '0;
      tmo_cnt      <= '0;
    end else begin
      busy         <= (state_nxt == S_FEED) || (state_nxt == S_DRAIN);
      done         <= (state_nxt == S_DONE);
      rd_en        <= (state_nxt == S_FEED);
      lyr_valid_in <= rd_en;
      if (accept) begin
        err       <= 1'b0;
        out_count <= '0;
        rd_addr   <= '0;
        tmo_cnt   <= '0;
      end else begin
        if ((state == S_FEED) && (rd_addr != RAW'(DIM - 1))) rd_addr <= rd_addr + RAW'(1);
        out_count <= cnt_nxt;
        if (beat_ovf || tmo_err) err <= 1'b1;
        // Idle counter only runs while draining; any beat restarts the window.
        if (state == S_DRAIN) tmo_cnt <= lyr_valid_out ? '0 : tmo_cnt + TW'(1);
        else                  tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Bench for layer_stream_ctrl: frame RAM and layer models, timing-level reference
// computed from the observed layer beat times.
module tb_layer_stream_ctrl;

  localparam int unsigned DW      = 32;
  localparam int unsigned CH      = 32;
  localparam int unsigned BW      = DW * CH;
  localparam int unsigned WIDTH   = 14;
  localparam int unsigned DIM     = WIDTH * WIDTH;
  localparam int unsigned DOUT    = 196;
  localparam int unsigned TIMEOUT = 300;
  localparam int unsigned RAW     = $clog2(DIM);
  localparam int unsigned WAW     = $clog2(DOUT);
  localparam int unsigned CW      = $clog2(DOUT + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           err;
  logic           rd_en;
  logic [RAW-1:0] rd_addr;
  logic [BW-1:0]  rd_data;
  logic [BW-1:0]  lyr_data;
  logic           lyr_valid_in;
  logic [BW-1:0]  lyr_out;
  logic           lyr_valid_out;
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [BW-1:0]  wr_data;
  logic [CW-1:0]  out_count;

  int errors = 0;
  int checks = 0;

  layer_stream_ctrl #(
    .DATA_WIDTH(DW), .CH(CH), .WIDTH(WIDTH), .DOUT(DOUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .lyr_data(lyr_data), .lyr_valid_in(lyr_valid_in),
    .lyr_out(lyr_out), .lyr_valid_out(lyr_valid_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Synchronous input frame buffer.
  logic [BW-1:0] mem [DIM];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Layer model: echo mode queues inputs and releases them after lat cycles with
  // random gaps; free-run mode emits fr_n beats back to back from the start edge.
  int            lat = 3;
  int            rate = 100;
  int            emit_limit = 0;
  int            fr_n = 0;
  bit            flush = 1'b0;
  bit            fr_go = 1'b0;
  logic [BW-1:0] fr_data[$];
  logic [BW-1:0] q_data[$];
  int            q_ready[$];
  int            pe = 0;
  int            pushed = 0;
  int            fr_left = 0;
  int            fr_idx = 0;

  always @(posedge clk) begin
    lyr_valid_out <= 1'b0;
    pe <= pe + 1;
    if (flush) begin
      q_data.delete();
      q_ready.delete();
      pushed <= 0;
    end
    if (fr_go || fr_left > 0) begin
      lyr_valid_out <= 1'b1;
      lyr_out       <= fr_data[fr_go ? 0 : fr_idx];
      fr_idx        <= (fr_go ? 0 : fr_idx) + 1;
      fr_left       <= (fr_go ? fr_n : fr_left) - 1;
    end else if (!flush) begin
      if (lyr_valid_in === 1'b1 && pushed < emit_limit) begin
        q_data.push_back(lyr_data);
        q_ready.push_back(pe + lat - 1);
        pushed <= pushed + 1;
      end
      if (q_data.size() > 0 && q_ready[0] <= pe && $urandom_range(99) < rate) begin
        lyr_valid_out <= 1'b1;
        lyr_out       <= q_data.pop_front();
        void'(q_ready.pop_front());
      end
    end
  end

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < int'(CH); i++) w[i*DW +: DW] = $urandom();
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/busy"},         64'(busy),         64'(0));
    chk({tag, "/done"},         64'(done),         64'(0));
    chk({tag, "/err"},          64'(err),          64'(0));
    chk({tag, "/rd_en"},        64'(rd_en),        64'(0));
    chk({tag, "/lyr_valid_in"}, 64'(lyr_valid_in), 64'(0));
    chk({tag, "/wr_en"},        64'(wr_en),        64'(0));
    chk({tag, "/rd_addr"},      64'(rd_addr),      64'(0));
    chk({tag, "/wr_addr"},      64'(wr_addr),      64'(0));
    chk({tag, "/out_count"},    64'(out_count),    64'(0));
  endtask

  // One frame: start pulse, per-cycle monitoring, then comparison with the reference.
  task automatic run_frame(input string tag, input bit free_run, input int n,
                           input int lat_i, input int rate_i, input bit poke,
                           input int abort_rel, input int tail);
    int            beat_rel[$];
    int            wr_rel[$];
    logic [WAW-1:0] wr_addr_q[$];
    logic [BW-1:0] wr_data_q[$];
    bit            busy_q[$];
    int            done_rels[$];
    int            bad_rd = 0;
    int            bad_vin = 0;
    int            bad_busy = 0;
    int            post = -1;
    int            nb, c, last, done_exp, n_acc;
    bit            ovf = 1'b0;
    logic          err_at_done = 1'bx;
    logic [CW-1:0] cnt_at_done = 'x;
    logic [BW-1:0] exp_d;

    @(negedge clk);
    lat = lat_i; rate = rate_i; emit_limit = n; fr_n = n;
    fr_data.delete();
    if (free_run) for (int i = 0; i < n; i++) fr_data.push_back(rand_word());
    flush = 1'b1; fr_go = free_run; start = 1'b1;

    for (int rel = 1; rel <= 1500; rel++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0; fr_go = 1'b0;
      if (rel == abort_rel) begin
        chk({tag, "/rd_addr_before_rst"}, 64'(rd_addr), 64'(abort_rel - 1));
        rst = 1'b1;
        #1;
        chk_idle({tag, "/async_rst"});
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({tag, "/no_done_in_rst"}, 64'(done), 64'(0));
        end
        rst = 1'b0;
        return;
      end
      if (rel == 1) chk({tag, "/err_cleared"}, 64'(err), 64'(0));
      if (rd_en !== 1'(rel <= int'(DIM))) bad_rd++;
      if (rd_en === 1'b1 && rd_addr !== RAW'(rel - 1)) bad_rd++;
      if (lyr_valid_in !== 1'(rel >= 2 && rel <= int'(DIM) + 1)) bad_vin++;
      busy_q.push_back(busy);
      if (lyr_valid_out === 1'b1) beat_rel.push_back(rel);
      if (wr_en === 1'b1) begin
        wr_rel.push_back(rel);
        wr_addr_q.push_back(wr_addr);
        wr_data_q.push_back(wr_data);
      end
      if (poke && rel == 50) start = 1'b1;
      if (done === 1'b1) begin
        done_rels.push_back(rel);
        err_at_done = err;
        cnt_at_done = out_count;
        if (post < 0) post = rel + tail;
        if (poke) start = 1'b1;
      end
      if (post >= 0 && rel >= post) break;
    end

    // Reference: frame ends one cycle after the DOUT-th beat (but not before the
    // reads finish and one DRAIN cycle passes), or TIMEOUT idle cycles into DRAIN.
    nb = beat_rel.size();
    if (nb >= int'(DOUT)) begin
      c = beat_rel[DOUT-1];
      done_exp = (c <= int'(DIM)) ? int'(DIM) + 2 : c + 1;
    end else begin
      last = (nb > 0) ? beat_rel[nb-1] : 0;
      done_exp = ((last > int'(DIM)) ? last : int'(DIM)) + int'(TIMEOUT) + 1;
    end
    n_acc = 0;
    for (int i = 0; i < nb; i++)
      if (beat_rel[i] < done_exp) begin
        if (i < int'(DOUT)) n_acc++;
        else ovf = 1'b1;
      end
    for (int i = 0; i < busy_q.size(); i++)
      if (busy_q[i] !== 1'((i + 1) < done_exp)) bad_busy++;

    chk({tag, "/done_count"}, 64'(done_rels.size()), 64'(1));
    chk({tag, "/done_cycle"}, 64'((done_rels.size() > 0) ? done_rels[0] : -1), 64'(done_exp));
    chk({tag, "/err"},        64'(err_at_done), 64'(ovf || (n_acc < int'(DOUT))));
    chk({tag, "/out_count"},  64'(cnt_at_done), 64'(n_acc));
    chk({tag, "/wr_count"},   64'(wr_rel.size()), 64'(n_acc));
    chk({tag, "/rd_seq"},     64'(bad_rd), 64'(0));
    chk({tag, "/valid_in"},   64'(bad_vin), 64'(0));
    chk({tag, "/busy"},       64'(bad_busy), 64'(0));
    for (int i = 0; i < n_acc && i < wr_rel.size(); i++) begin
      exp_d = free_run ? fr_data[i] : mem[i];
      chk({tag, "/wr_addr"},  64'(wr_addr_q[i]), 64'(i));
      chk({tag, "/wr_cycle"}, 64'(wr_rel[i]), 64'(beat_rel[i]));
      checks++;
      assert (wr_data_q[i] === exp_d) else begin
        errors++;
        $error("FAIL %s/wr_data[%0d]: observed=%h expected=%h", tag, i,
               wr_data_q[i][63:0], exp_d[63:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < int'(DIM); i++) mem[i] = rand_word();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    run_frame("nominal",     1'b0, DOUT, 3, 100, 1'b0, 0, 5);
    run_frame("rand_poke",   1'b0, DOUT, $urandom_range(1, 8), $urandom_range(60, 100), 1'b1, 0, 6);
    run_frame("timeout",     1'b0, 100,  $urandom_range(1, 8), $urandom_range(60, 100), 1'b0, 0, 3);
    run_frame("overflow",    1'b1, 200,  1, 100, 1'b0, 0, 4);
    run_frame("b2b_a",       1'b0, DOUT, 3, 100, 1'b0, 0, 0);
    run_frame("b2b_b",       1'b0, DOUT, 3, 100, 1'b0, 0, 4);
    run_frame("abort",       1'b0, DOUT, 3, 100, 1'b0, 51, 0);
    run_frame("after_abort", 1'b0, DOUT, $urandom_range(1, 8), $urandom_range(60, 100), 1'b0, 0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
